// File: rtl/countdown_timer.sv
// countdown_timer: keypad-driven MM:SS countdown timer.
//   clk, rst (async, active-low)
//   sw_timer             timer-mode switch, gates entry/start while idle
//   key_valid, key_code  one-cycle keypad event (0-9 digit, 10 '*', 11 '#')
//   tm_running/paused/alarm   one-hot state flags (all zero when idle)
//   tm_init_min/sec      time latched at the last successful start
//   tm_rem_min/sec       remaining time
module countdown_timer #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int ALARM_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_timer,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       tm_running,
  output logic       tm_paused,
  output logic       tm_alarm,
  output logic [5:0] tm_init_min,
  output logic [5:0] tm_init_sec,
  output logic [5:0] tm_rem_min,
  output logic [5:0] tm_rem_sec
);
  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  state_t              state_q, state_d;
  logic [3:0][3:0]     dig_q, dig_d;      // d3 d2 d1 d0, read as MM:SS
  logic [PW-1:0]       presc_q, presc_d;
  logic [AW-1:0]       asec_q, asec_d;    // seconds spent in ALARM
  logic [5:0]          imin_d, isec_d, rmin_d, rsec_d;

  logic                key_dig, key_star, key_hash, key_dismiss, tick;
  logic [PW-1:0]       presc_inc;
  logic [5:0]          start_min, start_sec, dmin, dsec;
  logic                dec_zero;

  function automatic logic [5:0] clamp59(input logic [3:0] hi, input logic [3:0] lo);
    logic [6:0] v;
    v = 7'(hi) * 7'd10 + 7'(lo);
    return (v > 7'd59) ? 6'd59 : v[5:0];
  endfunction

  always_comb begin
    key_dig     = key_valid && (key_code <= 4'd9);
    key_star    = key_valid && (key_code == 4'd10);
    key_hash    = key_valid && (key_code == 4'd11);
    key_dismiss = key_star || key_hash || (key_valid && key_code == 4'd0);
    tick        = (presc_q == PW'(TICK_DIV - 1));
    presc_inc   = tick ? '0 : presc_q + 1'b1;
    start_min   = clamp59(dig_q[3], dig_q[2]);
    start_sec   = clamp59(dig_q[1], dig_q[0]);
    if (tm_rem_sec != 6'd0) begin
      dmin = tm_rem_min;
      dsec = tm_rem_sec - 6'd1;
    end else begin
      dmin = tm_rem_min - 6'd1;
      dsec = 6'd59;
    end
    dec_zero = (dmin == 6'd0) && (dsec == 6'd0);
  end

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    presc_d = presc_q;
    asec_d  = asec_q;
    imin_d  = tm_init_min;
    isec_d  = tm_init_sec;
    rmin_d  = tm_rem_min;
    rsec_d  = tm_rem_sec;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        asec_d  = '0;
        if (!sw_timer) begin
          dig_d = '0;
        end else if (key_dig) begin
          dig_d = {dig_q[2:0], key_code};
        end else if (key_star) begin
          dig_d = '0;
        end else if (key_hash && ((start_min | start_sec) != 6'd0)) begin
          imin_d  = start_min;
          isec_d  = start_sec;
          rmin_d  = start_min;
          rsec_d  = start_sec;
          state_d = RUN;
        end
      end
      RUN: begin
        presc_d = presc_inc;
        if (key_hash) begin
          // abort beats a coincident tick
          state_d = IDLE;
          rmin_d  = '0;
          rsec_d  = '0;
          dig_d   = '0;
          presc_d = '0;
        end else begin
          if (tick) begin
            rmin_d = dmin;
            rsec_d = dsec;
          end
          // reaching 00:00 beats a coincident pause
          if (tick && dec_zero) begin
            state_d = ALARM;
            asec_d  = '0;
          end else if (key_star) begin
            state_d = PAUSE;
          end
        end
      end
      PAUSE: begin
        // prescaler holds its value so the resumed second is not lengthened
        if (key_star) begin
          state_d = RUN;
        end else if (key_hash) begin
          state_d = IDLE;
          rmin_d  = '0;
          rsec_d  = '0;
          dig_d   = '0;
          presc_d = '0;
        end
      end
      ALARM: begin
        presc_d = presc_inc;
        rmin_d  = '0;
        rsec_d  = '0;
        if (key_dismiss) begin
          state_d = IDLE;
          dig_d   = '0;
        end else if (tick) begin
          if (asec_q == AW'(ALARM_SEC - 1)) begin
            state_d = IDLE;
            dig_d   = '0;
          end else begin
            asec_d = asec_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      dig_q       <= '0;
      presc_q     <= '0;
      asec_q      <= '0;
      tm_running  <= 1'b0;
      tm_paused   <= 1'b0;
      tm_alarm    <= 1'b0;
      tm_init_min <= '0;
      tm_init_sec <= '0;
      tm_rem_min  <= '0;
      tm_rem_sec  <= '0;
    end else begin
      state_q     <= state_d;
      dig_q       <= dig_d;
      presc_q     <= presc_d;
      asec_q      <= asec_d;
      tm_running  <= (state_d == RUN);
      tm_paused   <= (state_d == PAUSE);
      tm_alarm    <= (state_d == ALARM);
      tm_init_min <= imin_d;
      tm_init_sec <= isec_d;
      tm_rem_min  <= rmin_d;
      tm_rem_sec  <= rsec_d;
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_timer = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       tm_running, tm_paused, tm_alarm;
  logic [5:0] tm_init_min, tm_init_sec, tm_rem_min, tm_rem_sec;

  countdown_timer #(.TICK_DIV(4), .ALARM_SEC(2)) dut (
    .clk(clk), .rst(rst), .sw_timer(sw_timer),
    .key_valid(key_valid), .key_code(key_code),
    .tm_running(tm_running), .tm_paused(tm_paused), .tm_alarm(tm_alarm),
    .tm_init_min(tm_init_min), .tm_init_sec(tm_init_sec),
    .tm_rem_min(tm_rem_min), .tm_rem_sec(tm_rem_sec)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] flags;   // running, paused, alarm
    logic [5:0] imin, isec, rmin, rsec;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // expectation for the sampling point k cycles from now
  task automatic expect_at(input int k, input string name, input logic [2:0] flags,
                           input int imin, input int isec, input int rmin, input int rsec);
    exp_t e;
    e.cyc = cyc + k; e.name = name; e.flags = flags;
    e.imin = 6'(imin); e.isec = 6'(isec); e.rmin = 6'(rmin); e.rsec = 6'(rsec);
    q.push_back(e);
  endtask

  // monitor: samples 1 time unit after each falling edge
  initial forever begin
    exp_t e;
    logic [2:0] f;
    @(negedge clk);
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_checks++;
      f = {tm_running, tm_paused, tm_alarm};
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: sample point cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (f !== e.flags || tm_init_min !== e.imin || tm_init_sec !== e.isec ||
                   tm_rem_min !== e.rmin || tm_rem_sec !== e.rsec) begin
        n_fail++;
        $display("FAIL %s @%0d: got flags=%b init=%0d:%0d rem=%0d:%0d, expected flags=%b init=%0d:%0d rem=%0d:%0d",
                 e.name, cyc, f, tm_init_min, tm_init_sec, tm_rem_min, tm_rem_sec,
                 e.flags, e.imin, e.isec, e.rmin, e.rsec);
      end
    end
  end

  // drive a key at the current falling edge; it is sampled on the next rising edge
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam logic [2:0] F_IDLE = 3'b000, F_RUN = 3'b100, F_PAU = 3'b010, F_ALM = 3'b001;

  initial begin
    // reset state
    wait_cyc(3);
    expect_at(0, "reset", F_IDLE, 0, 0, 0, 0);
    rst = 1'b1;
    sw_timer = 1'b1;
    wait_cyc(1);

    // 00:03 runs down to alarm after 12 cycles
    enter(0, 0, 0, 3); press(11);
    expect_at(0,  "start3",   F_RUN, 0, 3, 0, 3);
    expect_at(3,  "nodec3",   F_RUN, 0, 3, 0, 3);
    expect_at(4,  "dec3",     F_RUN, 0, 3, 0, 2);
    expect_at(11, "pre_alm",  F_RUN, 0, 3, 0, 1);
    expect_at(12, "alarm1",   F_ALM, 0, 3, 0, 0);
    wait_cyc(12);
    press(0);
    expect_at(0, "alarm_key0", F_IDLE, 0, 3, 0, 0);

    // clamp to 59:59, then abort keeps init
    enter(9, 9, 7, 5); press(11);
    expect_at(0, "clamp", F_RUN, 59, 59, 59, 59);
    wait_cyc(1);
    press(11);
    expect_at(0, "abort_run", F_IDLE, 59, 59, 0, 0);

    // minute rollover
    enter(0, 1, 0, 0); press(11);
    expect_at(0, "roll_start", F_RUN, 1, 0, 1, 0);
    expect_at(4, "rollover",   F_RUN, 1, 0, 0, 59);
    wait_cyc(4);
    press(11);
    expect_at(0, "abort_roll", F_IDLE, 1, 0, 0, 0);

    // pause two cycles after start, resume, then alarm timeout
    enter(0, 0, 0, 5); press(11);
    wait_cyc(1);
    press(10);
    expect_at(0,  "pause",      F_PAU, 0, 5, 0, 5);
    expect_at(20, "pause_hold", F_PAU, 0, 5, 0, 5);
    wait_cyc(20);
    press(10);
    expect_at(0,  "resume",       F_RUN, 0, 5, 0, 5);
    expect_at(1,  "resume_nodec", F_RUN, 0, 5, 0, 5);
    expect_at(2,  "resume_dec",   F_RUN, 0, 5, 0, 4);
    expect_at(18, "alarm2",       F_ALM, 0, 5, 0, 0);
    expect_at(25, "alarm_last",   F_ALM, 0, 5, 0, 0);
    expect_at(26, "alarm_expire", F_IDLE, 0, 5, 0, 0);
    wait_cyc(26);

    // ignored input: switch off, zero total
    sw_timer = 1'b0;
    press(1); press(11);
    expect_at(0, "sw_off", F_IDLE, 0, 5, 0, 0);
    sw_timer = 1'b1;
    press(11);
    expect_at(0, "zero_start", F_IDLE, 0, 5, 0, 0);
    enter(0, 0, 0, 0); press(11);
    expect_at(0, "zero_entry", F_IDLE, 0, 5, 0, 0);

    // key 13 in RUN ignored; tick to 00:00 with '*' -> alarm
    enter(0, 0, 0, 2); press(11);
    press(13);
    expect_at(0, "key13",     F_RUN, 0, 2, 0, 2);
    expect_at(3, "key13_dec", F_RUN, 0, 2, 0, 1);
    wait_cyc(3);
    wait_cyc(3);
    press(10);
    expect_at(0, "alarm_wins", F_ALM, 0, 2, 0, 0);
    press(11);
    expect_at(0, "alarm_hash", F_IDLE, 0, 2, 0, 0);

    // tick with '#' -> abort; tick with '*' -> pause with decrement
    enter(0, 0, 1, 0); press(11);
    wait_cyc(3);
    press(11);
    expect_at(0, "tick_abort", F_IDLE, 0, 10, 0, 0);
    enter(0, 0, 1, 0); press(11);
    wait_cyc(3);
    press(10);
    expect_at(0, "tick_pause", F_PAU, 0, 10, 0, 9);
    press(11);
    expect_at(0, "abort_pause", F_IDLE, 0, 10, 0, 0);

    // asynchronous reset mid-RUN
    enter(0, 0, 1, 0); press(11);
    wait_cyc(2);
    expect_at(1, "async_rst", F_IDLE, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expect_at(1, "post_rst", F_IDLE, 0, 0, 0, 0);
    wait_cyc(3);
    #2;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pending: %0d expectations never sampled, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
